cms_ctrl_sequencer: RTL and testbench

Arbitrates configuration writes from two requesters onto the single control port (ctrl_addr / ctrl_wdata / ctrl_write_enable) of the continuous monitoring system. Port 0 is the host-side requester (GPIO/AXI-lite bridge); port 1 is the internal trigger/config unit. Each accepted write is replayed as one clean, edge-qualified write-enable pulse, guaranteeing a rising edge per write for the CMS's posedge-triggered control interface. The block sits between the requesters and the CMS control inputs.

---
 rtl/cms_ctrl_sequencer_if.sv | 35 +++
 rtl/cms_ctrl_sequencer.sv | 93 +++++++++
 tb/tb_cms_ctrl_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cms_ctrl_sequencer_if.sv
// Request and control-port bundle for cms_ctrl_sequencer.
// master = requester side (drives valid/payload), slave = the sequencer.
interface cms_ctrl_sequencer_if #(
    parameter int CTRL_ADDR_WIDTH = 8,
    parameter int CTRL_DATA_WIDTH = 64
);
    // A request transfers on a rising clk edge where valid & ready are both high;
    // the requester holds valid and payload steady until then, and ready never
    // depends combinationally on anything other than FSM state and the grant.
    logic                       req0_valid;
    logic                       req0_ready;
    logic [CTRL_ADDR_WIDTH-1:0] req0_addr;
    logic [CTRL_DATA_WIDTH-1:0] req0_wdata;
    logic                       req1_valid;
    logic                       req1_ready;
    logic [CTRL_ADDR_WIDTH-1:0] req1_addr;
    logic [CTRL_DATA_WIDTH-1:0] req1_wdata;
    logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr;
    logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata;
    logic                       ctrl_write_enable;

    modport master (
        output req0_valid, req0_addr, req0_wdata,
        output req1_valid, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  ctrl_addr, ctrl_wdata, ctrl_write_enable
    );

    modport slave (
        input  req0_valid, req0_addr, req0_wdata,
        input  req1_valid, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output ctrl_addr, ctrl_wdata, ctrl_write_enable
    );
endinterface

// File: rtl/cms_ctrl_sequencer.sv
// Round-robin arbiter for two config requesters onto the CMS control port; each
// accepted write is replayed as one registered, edge-qualified write-enable pulse.
module cms_ctrl_sequencer #(
    parameter int CTRL_ADDR_WIDTH = 8,
    parameter int CTRL_DATA_WIDTH = 64,
    parameter int PULSE_HIGH      = 1,
    parameter int PULSE_LOW       = 1,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cms_ctrl_sequencer_if.slave  bus,
    output logic                 busy,
    output logic                 last_grant,
    output logic [CNT_WIDTH-1:0] writes_issued,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;

    localparam int PMAX = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
    localparam int PCW  = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [PCW-1:0] HIGH_LOAD = PCW'(PULSE_HIGH - 1);
    localparam logic [PCW-1:0] LOW_LOAD  = PCW'(PULSE_LOW - 1);

    state_t                     state, state_next;
    logic [PCW-1:0]             pulse_cnt, pulse_cnt_next;
    logic                       we_q;
    logic [CTRL_ADDR_WIDTH-1:0] addr_q;
    logic [CTRL_DATA_WIDTH-1:0] wdata_q;
    logic                       grant0, grant1, hs0, hs1;

    // last_grant resets to 1 so port 0 wins the first tie.
    always_comb begin
        grant0         = bus.req0_valid & (~bus.req1_valid | last_grant);
        grant1         = bus.req1_valid & (~bus.req0_valid | ~last_grant);
        bus.req0_ready = (state == IDLE) & grant0;
        bus.req1_ready = (state == IDLE) & grant1;
        hs0            = bus.req0_valid & bus.req0_ready;
        hs1            = bus.req1_valid & bus.req1_ready;
        state_next     = state;
        pulse_cnt_next = pulse_cnt;
        case (state)
            IDLE:  if (hs0 | hs1) state_next = SETUP;
            SETUP: begin
                state_next     = HIGH;
                pulse_cnt_next = HIGH_LOAD;
            end
            HIGH: begin
                if (pulse_cnt == '0) begin
                    state_next     = LOW;
                    pulse_cnt_next = LOW_LOAD;
                end else begin
                    pulse_cnt_next = pulse_cnt - PCW'(1);
                end
            end
            LOW: begin
                if (pulse_cnt == '0) state_next = IDLE;
                else                 pulse_cnt_next = pulse_cnt - PCW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Enable is a flop loaded from the next state, so it is glitch-free and
    // clears asynchronously with rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pulse_cnt     <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            last_grant    <= 1'b1;
            writes_issued <= '0;
        end else begin
            state     <= state_next;
            pulse_cnt <= pulse_cnt_next;
            we_q      <= (state_next == HIGH);
            if (hs0 | hs1) begin
                addr_q     <= hs1 ? bus.req1_addr  : bus.req0_addr;
                wdata_q    <= hs1 ? bus.req1_wdata : bus.req0_wdata;
                last_grant <= hs1;
            end
            if (state == SETUP) writes_issued <= writes_issued + CNT_WIDTH'(1);
        end
    end

    assign bus.ctrl_addr         = addr_q;
    assign bus.ctrl_wdata        = wdata_q;
    assign bus.ctrl_write_enable = we_q;
    assign busy                  = (state != IDLE);
    assign state_dbg             = state;
endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// Directed bench for cms_ctrl_sequencer: default, long-pulse and narrow-counter
// instances share one clock and reset.
module tb_cms_ctrl_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cms_ctrl_sequencer_if if_a ();
  cms_ctrl_sequencer_if if_b ();
  cms_ctrl_sequencer_if if_c ();

  logic        busy_a, lg_a, busy_b, lg_b, busy_c, lg_c;
  logic [15:0] wi_a, wi_b;
  logic [3:0]  wi_c;
  logic [1:0]  st_a, st_b, st_c;

  cms_ctrl_sequencer dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave), .busy(busy_a), .last_grant(lg_a),
    .writes_issued(wi_a), .state_dbg(st_a)
  );
  cms_ctrl_sequencer #(.PULSE_HIGH(3), .PULSE_LOW(2)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave), .busy(busy_b), .last_grant(lg_b),
    .writes_issued(wi_b), .state_dbg(st_b)
  );
  cms_ctrl_sequencer #(.CNT_WIDTH(4)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave), .busy(busy_c), .last_grant(lg_c),
    .writes_issued(wi_c), .state_dbg(st_c)
  );

  task automatic init_inputs();
    if_a.req0_valid = 0; if_a.req0_addr = '0; if_a.req0_wdata = '0;
    if_a.req1_valid = 0; if_a.req1_addr = '0; if_a.req1_wdata = '0;
    if_b.req0_valid = 0; if_b.req0_addr = '0; if_b.req0_wdata = '0;
    if_b.req1_valid = 0; if_b.req1_addr = '0; if_b.req1_wdata = '0;
    if_c.req0_valid = 0; if_c.req0_addr = '0; if_c.req0_wdata = '0;
    if_c.req1_valid = 0; if_c.req1_addr = '0; if_c.req1_wdata = '0;
  endtask

  task automatic test_reset();
    if_a.req0_valid = 1; if_a.req1_valid = 1;
    @(negedge clk);
    checks++; if (if_a.ctrl_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", if_a.ctrl_addr); end
    checks++; if (if_a.ctrl_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", if_a.ctrl_wdata); end
    checks++; if (if_a.ctrl_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", if_a.ctrl_write_enable); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (lg_a !== 1'b1) begin errors++; $display("FAIL reset_last_grant: got %b expected 1", lg_a); end
    checks++; if (wi_a !== 16'd0) begin errors++; $display("FAIL reset_writes: got %0d expected 0", wi_a); end
    checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st_a); end
    checks++; if (if_a.req0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b expected 1", if_a.req0_ready); end
    checks++; if (if_a.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b expected 0", if_a.req1_ready); end
    @(posedge clk); #1;
    if_a.req0_valid = 0; if_a.req1_valid = 0;
    rst = 0;
  endtask

  task automatic test_single_write();
    if_a.req0_valid = 1; if_a.req0_addr = 8'h05; if_a.req0_wdata = 64'h1234;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (if_a.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", if_a.req0_ready); end
      end
      if (c == 1) begin
        checks++; if (if_a.ctrl_addr !== 8'h05) begin errors++; $display("FAIL single_addr: got %h expected 05", if_a.ctrl_addr); end
        checks++; if (if_a.ctrl_wdata !== 64'h1234) begin errors++; $display("FAIL single_wdata: got %h expected 1234", if_a.ctrl_wdata); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_t1: got %b expected 1", busy_a); end
      end
      checks++; if (if_a.ctrl_write_enable !== (c == 2)) begin errors++; $display("FAIL single_we c=%0d: got %b expected %b", c, if_a.ctrl_write_enable, c == 2); end
      if (c == 2) begin
        checks++; if (wi_a !== 16'd1) begin errors++; $display("FAIL single_writes: got %0d expected 1", wi_a); end
      end
      if (c == 4) begin
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_t4: got %b expected 0", busy_a); end
      end
      @(posedge clk); #1;
      if (c == 0) if_a.req0_valid = 0;
    end
  endtask

  task automatic test_tie();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    if_a.req0_valid = 1; if_a.req0_addr = 8'h01; if_a.req0_wdata = 64'h11;
    if_a.req1_valid = 1; if_a.req1_addr = 8'h02; if_a.req1_wdata = 64'h22;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++; if (if_a.req0_ready !== (c == 0 || c == 8)) begin errors++; $display("FAIL tie_ready0 c=%0d: got %b", c, if_a.req0_ready); end
      checks++; if (if_a.req1_ready !== (c == 4)) begin errors++; $display("FAIL tie_ready1 c=%0d: got %b", c, if_a.req1_ready); end
      checks++; if (if_a.ctrl_write_enable !== (c % 4 == 2)) begin errors++; $display("FAIL tie_we c=%0d: got %b", c, if_a.ctrl_write_enable); end
      checks++; if (busy_a !== (c % 4 != 0)) begin errors++; $display("FAIL tie_busy c=%0d: got %b", c, busy_a); end
      if (c % 4 == 1) begin
        checks++;
        if (if_a.ctrl_addr !== ((c == 5) ? 8'h02 : 8'h01)) begin
          errors++; $display("FAIL tie_addr c=%0d: got %h expected %h", c, if_a.ctrl_addr, (c == 5) ? 8'h02 : 8'h01);
        end
      end
      @(posedge clk); #1;
    end
    if_a.req0_valid = 0; if_a.req1_valid = 0;
    checks++; if (wi_a !== 16'd3) begin errors++; $display("FAIL tie_writes: got %0d expected 3", wi_a); end
  endtask

  task automatic test_hold();
    if_a.req0_valid = 1; if_a.req0_addr = 8'h10; if_a.req0_wdata = 64'h10;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (if_a.req0_ready !== 1'b1) begin errors++; $display("FAIL hold_ready0: got %b expected 1", if_a.req0_ready); end
      end
      if (c == 2 || c == 3) begin
        checks++; if (if_a.req1_ready !== 1'b0) begin errors++; $display("FAIL hold_ready1_busy c=%0d: got %b expected 0", c, if_a.req1_ready); end
        checks++; if (if_a.ctrl_addr !== 8'h10) begin errors++; $display("FAIL hold_addr c=%0d: got %h expected 10", c, if_a.ctrl_addr); end
        checks++; if (if_a.ctrl_wdata !== 64'h10) begin errors++; $display("FAIL hold_wdata c=%0d: got %h expected 10", c, if_a.ctrl_wdata); end
      end
      if (c == 4) begin
        checks++; if (if_a.req1_ready !== 1'b1) begin errors++; $display("FAIL hold_ready1_idle: got %b expected 1", if_a.req1_ready); end
      end
      if (c == 5) begin
        checks++; if (if_a.ctrl_addr !== 8'h44) begin errors++; $display("FAIL hold_new_addr: got %h expected 44", if_a.ctrl_addr); end
        checks++; if (if_a.ctrl_wdata !== 64'hBB) begin errors++; $display("FAIL hold_new_wdata: got %h expected bb", if_a.ctrl_wdata); end
      end
      @(posedge clk); #1;
      if (c == 0) if_a.req0_valid = 0;
      if (c == 1) begin if_a.req1_valid = 1; if_a.req1_addr = 8'h33; if_a.req1_wdata = 64'hAA; end
      if (c == 2) begin if_a.req1_addr = 8'h44; if_a.req1_wdata = 64'hBB; end
      if (c == 4) if_a.req1_valid = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL hold_idle: got %b expected 0", busy_a); end
    checks++; if (lg_a !== 1'b1) begin errors++; $display("FAIL hold_last_grant: got %b expected 1", lg_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_pulse_shape();
    int edges;
    logic prev_we;
    edges = 0; prev_we = 1'b0;
    if_b.req0_valid = 1; if_b.req0_addr = 8'h7E; if_b.req0_wdata = 64'h5;
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      checks++;
      if (if_b.ctrl_write_enable !== ((c % 7) >= 2 && (c % 7) <= 4)) begin
        errors++; $display("FAIL pulse_we c=%0d: got %b", c, if_b.ctrl_write_enable);
      end
      if (if_b.ctrl_write_enable === 1'b1 && prev_we === 1'b0) edges++;
      prev_we = if_b.ctrl_write_enable;
      @(posedge clk); #1;
      if (c == 14) if_b.req0_valid = 0;
    end
    checks++; if (edges !== 3) begin errors++; $display("FAIL pulse_edges: got %0d expected 3", edges); end
    checks++; if (wi_b !== 16'd3) begin errors++; $display("FAIL pulse_writes: got %0d expected 3", wi_b); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL pulse_idle: got %b expected 0", busy_b); end
  endtask

  task automatic test_async_reset();
    if_a.req0_valid = 1; if_a.req0_addr = 8'h66; if_a.req0_wdata = 64'h66;
    @(negedge clk);
    @(posedge clk); #1;
    if_a.req0_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (if_a.ctrl_write_enable !== 1'b1) begin errors++; $display("FAIL arst_pre_we: got %b expected 1", if_a.ctrl_write_enable); end
    checks++; if (wi_a !== 16'd6) begin errors++; $display("FAIL arst_pre_writes: got %0d expected 6", wi_a); end
    #2 rst = 1;
    #1;
    checks++; if (if_a.ctrl_write_enable !== 1'b0) begin errors++; $display("FAIL arst_we: got %b expected 0", if_a.ctrl_write_enable); end
    checks++; if (if_a.ctrl_addr !== 8'h00) begin errors++; $display("FAIL arst_addr: got %h expected 00", if_a.ctrl_addr); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy_a); end
    checks++; if (wi_a !== 16'd0) begin errors++; $display("FAIL arst_writes: got %0d expected 0", wi_a); end
    checks++; if (lg_a !== 1'b1) begin errors++; $display("FAIL arst_last_grant: got %b expected 1", lg_a); end
    @(posedge clk); #1;
    rst = 0;
    if_a.req0_valid = 1; if_a.req0_addr = 8'h01;
    if_a.req1_valid = 1; if_a.req1_addr = 8'h02;
    @(negedge clk);
    checks++; if (if_a.req0_ready !== 1'b1) begin errors++; $display("FAIL arst_tie_ready0: got %b expected 1", if_a.req0_ready); end
    checks++; if (if_a.req1_ready !== 1'b0) begin errors++; $display("FAIL arst_tie_ready1: got %b expected 0", if_a.req1_ready); end
    @(posedge clk); #1;
    if_a.req0_valid = 0; if_a.req1_valid = 0;
    @(negedge clk);
    checks++; if (if_a.ctrl_addr !== 8'h01) begin errors++; $display("FAIL arst_tie_addr: got %h expected 01", if_a.ctrl_addr); end
    checks++; if (lg_a !== 1'b0) begin errors++; $display("FAIL arst_tie_grant: got %b expected 0", lg_a); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    int edges;
    logic prev_we;
    edges = 0; prev_we = 1'b0;
    if_c.req0_valid = 1; if_c.req0_addr = 8'h9; if_c.req0_wdata = 64'h9;
    for (int c = 0; c <= 66; c++) begin
      @(negedge clk);
      if (if_c.ctrl_write_enable === 1'b1 && prev_we === 1'b0) edges++;
      prev_we = if_c.ctrl_write_enable;
      if (c == 58) begin
        checks++; if (wi_c !== 4'd15) begin errors++; $display("FAIL wrap_15: got %0d expected 15", wi_c); end
      end
      if (c == 62) begin
        checks++; if (wi_c !== 4'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", wi_c); end
      end
      if (c == 66) begin
        checks++; if (wi_c !== 4'd1) begin errors++; $display("FAIL wrap_1: got %0d expected 1", wi_c); end
      end
      @(posedge clk); #1;
      if (c == 64) if_c.req0_valid = 0;
    end
    checks++; if (edges !== 17) begin errors++; $display("FAIL wrap_edges: got %0d expected 17", edges); end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_write();
    test_tie();
    test_hold();
    test_pulse_shape();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
